// File: rtl/mfda_route_sequencer.sv
// mfda_route_sequencer: valve sequencer for a microfluidic route (open/settle, peristaltic pump, close/settle, done).
// Optional reverse pumping via MFDA_PUMP_REVERSE_EN (adds cmd_dir).
module mfda_route_sequencer #(
  parameter int N_SRC      = 3,
  parameter int N_DST      = 2,
  parameter int N_PUMP     = 3,
  parameter int SETTLE_CYC = 4,
  parameter int STEP_CYC   = 8,
  parameter int STROKE_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [$clog2(N_SRC)-1:0] cmd_src,
  input  logic [$clog2(N_DST)-1:0] cmd_dst,
  input  logic [STROKE_W-1:0]      cmd_strokes,
`ifdef MFDA_PUMP_REVERSE_EN
  input  logic                     cmd_dir,
`endif
  input  logic                     cmd_abort,
  output logic [N_SRC-1:0]         src_open,
  output logic [N_DST-1:0]         dst_open,
  output logic [N_PUMP-1:0]        pump_open,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     err
);
  localparam int SW   = $clog2(N_SRC);
  localparam int DW   = $clog2(N_DST);
  localparam int PW   = $clog2(N_PUMP);
  localparam int MAXC = SETTLE_CYC > STEP_CYC ? SETTLE_CYC : STEP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SET_END  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] STEP_END = CW'(STEP_CYC - 1);
  localparam logic [PW-1:0] LAST     = PW'(N_PUMP - 1);
  typedef enum logic [1:0] {IDLE, OPEN, PUMP, CLOSE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] step_q, step_d, pidx;
  logic [STROKE_W-1:0] strk_q, strk_d;
  logic [SW-1:0] src_q, src_d;
  logic [DW-1:0] dst_q, dst_d;
  logic aborted_q, aborted_d, done_q, done_d, err_q, err_d, busy_q, busy_d, dir_d, acc, bad, route;
  logic [N_SRC-1:0] src_open_q, src_open_d;
  logic [N_DST-1:0] dst_open_q, dst_open_d;
  logic [N_PUMP-1:0] pump_open_q, pump_open_d;
  assign cmd_ready = state_q == IDLE && !rst;
  assign acc = cmd_valid && cmd_ready;
  assign bad = 32'(cmd_src) >= N_SRC || 32'(cmd_dst) >= N_DST || cmd_strokes == '0;
`ifdef MFDA_PUMP_REVERSE_EN
  logic dir_q;
  always_ff @(posedge clk) dir_q <= rst ? 1'b0 : dir_d;
`else
  assign dir_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      step_q      <= '0;
      strk_q      <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      aborted_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      src_open_q  <= '0;
      dst_open_q  <= '0;
      pump_open_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      strk_q      <= strk_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      aborted_q   <= aborted_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      src_open_q  <= src_open_d;
      dst_open_q  <= dst_open_d;
      pump_open_q <= pump_open_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    strk_d    = strk_q;
    src_d     = src_q;
    dst_d     = dst_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef MFDA_PUMP_REVERSE_EN
    dir_d     = dir_q;
`endif
    if (cmd_abort && (state_q == OPEN || state_q == PUMP)) begin
      state_d   = CLOSE;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (acc) begin
          if (bad) err_d = 1'b1;
          else begin
            state_d   = OPEN;
            cnt_d     = '0;
            src_d     = cmd_src;
            dst_d     = cmd_dst;
            strk_d    = cmd_strokes;
            aborted_d = 1'b0;
`ifdef MFDA_PUMP_REVERSE_EN
            dir_d     = cmd_dir;
`endif
          end
        end
        OPEN: begin
          cnt_d   = cnt_q == SET_END ? '0 : cnt_q + 1'b1;
          step_d  = '0;
          state_d = cnt_q == SET_END ? PUMP : OPEN;
        end
        PUMP: if (cnt_q != STEP_END) cnt_d = cnt_q + 1'b1;
        else begin
          cnt_d  = '0;
          step_d = step_q == LAST ? '0 : step_q + 1'b1;
          // a stroke ends after the last pump valve; the final stroke ends the pump phase
          if (step_q == LAST) begin
            strk_d  = strk_q - 1'b1;
            state_d = strk_q == STROKE_W'(1) ? CLOSE : PUMP;
          end
        end
        CLOSE: begin
          cnt_d   = cnt_q == SET_END ? '0 : cnt_q + 1'b1;
          done_d  = cnt_q == SET_END;
          state_d = cnt_q == SET_END ? IDLE : CLOSE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    route       = state_d == OPEN || state_d == PUMP;
    pidx        = dir_d ? LAST - step_d : step_d;
    src_open_d  = route ? N_SRC'(1) << src_d : '0;
    dst_open_d  = route ? N_DST'(1) << dst_d : '0;
    pump_open_d = state_d == PUMP ? N_PUMP'(1) << pidx : '0;
    busy_d      = state_d != IDLE;
  end
  assign src_open  = src_open_q;
  assign dst_open  = dst_open_q;
  assign pump_open = pump_open_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = err_q;
endmodule

// File: doc/mfda_route_sequencer.md
Name: mfda_route_sequencer

Overview:
- Clocked controller for the pneumatic control lines of a parametrised microfluidic routing network: N_SRC inlet valves, N_DST outlet valves, and an N_PUMP-valve peristaltic pump.
- Accepts a route command (source, destination, stroke count) over a valid/ready handshake, then sequences the valves through four phases: open and settle, pump, close and settle, report done.
- Replaces hand-driven per-valve air inputs, such as c*/p* lines, in generated chip tops. Its outputs drive the air_in pins of valve instances.

Parameters:
- N_SRC, 3, number of source/inlet valves (>=2)
- N_DST, 2, number of destination/outlet valves (>=2)
- N_PUMP, 3, number of pump valves in the peristaltic chain (>=3)
- SETTLE_CYC, 4, cycles held after opening and after closing route valves (>=1)
- STEP_CYC, 8, cycles per pump step (>=1)
- STROKE_W, 8, width of the stroke count

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_src  input  $clog2(N_SRC)  source valve index
- cmd_dst  input  $clog2(N_DST)  destination valve index
- cmd_strokes  input  STROKE_W  number of full pump strokes
- cmd_abort  input  1  abort the current route (level, sampled every cycle)
- src_open  output  N_SRC  source valve open commands (1 = open)
- dst_open  output  N_DST  destination valve open commands
- pump_open  output  N_PUMP  pump valve open commands
- busy  output  1  high when the state is not IDLE
- done  output  1  one-cycle pulse on return to IDLE
- aborted  output  1  last route ended by abort; held until the next accepted command
- err  output  1  one-cycle pulse when a command is rejected

Behaviour:
- Clocking and reset:
  - Everything is registered. Reset is synchronous and active-high on clk.
  - Reset values: all *_open = 0, busy = 0, done = 0, err = 0, aborted = 0, state = IDLE.
  - cmd_ready is 0 while rst is high.
  - Reset mid-route closes all valves on the next edge; no done pulse is produced.
- Handshake:
  - cmd_ready = (state == IDLE) and not rst.
  - A command is accepted on an edge where cmd_valid and cmd_ready are both high.
  - Fields are latched at acceptance and ignored afterwards.
- Validation:
  - A command is invalid if cmd_src >= N_SRC, cmd_dst >= N_DST, or cmd_strokes == 0.
  - An invalid command still completes the handshake. err pulses the following cycle, state stays IDLE, no valve moves, and aborted is unchanged.
- FSM states and transitions:
  - IDLE: all valves closed.
  - OPEN_SETTLE (SETTLE_CYC cycles): src_open and dst_open are one-hot at the latched indices; pump_open = 0.
  - PUMP: route valves stay open. There are cmd_strokes*N_PUMP steps of STEP_CYC cycles each. pump_open is one-hot; step k of each stroke opens bit k, starting at bit 0 and rotating upward. The rotation wraps to bit 0 for each new stroke.
  - CLOSE_SETTLE (SETTLE_CYC cycles): all valves closed.
  - Return to IDLE: done = 1 for exactly the first IDLE cycle. cmd_ready is also high in that cycle, so a back-to-back command is accepted on the same edge.
- Latency:
  - Take the acceptance edge as cycle 0. Valve outputs change at cycle 1.
  - done is high at cycle 1 + 2*SETTLE_CYC + strokes*N_PUMP*STEP_CYC.
- Counters:
  - Cycle, step and stroke counters are sized with $clog2. No counter may wrap within a legal command.
  - cmd_strokes = 2^STROKE_W-1 must complete exactly.
- Abort:
  - cmd_abort high in OPEN_SETTLE or PUMP: the next edge enters CLOSE_SETTLE with all valves closed and sets aborted = 1. done still pulses afterwards.
  - Abort in IDLE or CLOSE_SETTLE is ignored.
  - If abort and the normal phase end occur in the same cycle, abort wins.
- Invariants: at most one src_open bit, at most one dst_open bit, and at most one pump_open bit are high at any time.

Optional Feature:
- Macro: MFDA_PUMP_REVERSE_EN.
- Defined:
  - Adds input cmd_dir (1 bit), latched at acceptance.
  - cmd_dir = 1 pumps in reverse: each stroke opens bit N_PUMP-1 first and rotates downward.
  - cmd_dir = 0 behaves exactly as forward.
- Undefined: cmd_dir port is absent and direction is always forward.

Test Plan:
- Defaults; accept src=1, dst=0, strokes=2 at cycle 0 -> src_open=010 and dst_open=01 from cycle 1. pump_open goes 001,010,100,001,010,100, each held 8 cycles, over cycles 5–52. All valves close at 53. done=1 only at cycle 57.
- Command with strokes=0, then src=3 (with N_SRC=3) -> err pulses one cycle each, busy stays 0, all valves stay 0.
- cmd_abort at the 3rd cycle of pump step 4 -> next cycle all valves 0, then 4 close cycles, done pulse, aborted=1. aborted clears on the next valid accept.
- rst asserted during PUMP -> next edge all outputs 0, no done; cmd_ready=1 the cycle after rst drops.
- Back-to-back: cmd_valid held high with a second command -> second command accepted in the done cycle; its valves open on the next cycle.
- MFDA_PUMP_REVERSE_EN defined, cmd_dir=1, strokes=1 -> pump_open sequence 100,010,001.
